// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a multicycle MIPS-style datapath
module multicycle_ctrl #(
  parameter bit MEM_HS = 1'b1,
  parameter bit EN_JAL = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCCondSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       ExtZero,
  output logic       illegal,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [4:0] state
);
  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_EXLS = 5'd2, S_MEMRD = 5'd3, S_WBLS = 5'd4,
    S_MEMST = 5'd5, S_EXR = 5'd6, S_WBR = 5'd7, S_BEQ = 5'd8, S_J = 5'd9,
    S_BNE = 5'd10, S_EXI = 5'd11, S_WBI = 5'd12, S_JAL = 5'd13, S_JR = 5'd14,
    S_TRAP = 5'd15, S_RESET = 5'd31
  } state_t;
  state_t st, nxt;
  logic [1:0] icls;
  logic ready;
  state_t bad;
  assign state = st;
  assign ready = mem_ready | ~MEM_HS;
  assign bad = TRAP_ILLEGAL ? S_TRAP : S_EXR;
  // state register; reset lands in RESET so outputs stay quiet one cycle after release
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= S_RESET;
    else st <= nxt;
  // immediate class latched at decode so EX_I outputs depend on state registers only
  always_ff @(posedge clk or posedge rst)
    if (rst) icls <= 2'd0;
    else if (st == S_ID) icls <= OP == 6'b001010 ? 2'd1 : OP == 6'b001100 ? 2'd2 : OP == 6'b001101 ? 2'd3 : 2'd0;
  // next-state decode and per-state datapath controls
  always_comb begin
    nxt = S_IF;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    PCCondSrc = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ExtZero = 1'b0;
    illegal = 1'b0;
    RegDst = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    ALUOp = 3'b000;
    case (st)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = ready;
        IRWrite = ready;
        nxt = ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (OP)
          6'b000000: nxt = (EN_JAL && funct == 6'b001000) ? S_JR : S_EXR;
          6'b000010: nxt = S_J;
          6'b000011: nxt = EN_JAL ? S_JAL : bad;
          6'b000100: nxt = S_BEQ;
          6'b000101: nxt = S_BNE;
          6'b001000, 6'b001010, 6'b001100, 6'b001101: nxt = S_EXI;
          6'b100011, 6'b101011: nxt = S_EXLS;
          default: nxt = bad;
        endcase
      end
      S_EXLS: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt = OP == 6'b101011 ? S_MEMST : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        nxt = ready ? S_WBLS : S_MEMRD;
      end
      S_MEMST: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        nxt = ready ? S_IF : S_MEMST;
      end
      S_WBLS: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        ALUOp = 3'b010;
        nxt = S_WBR;
      end
      S_WBR: begin
        RegWrite = 1'b1;
        RegDst = 2'b01;
      end
      S_EXI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp = icls == 2'd1 ? 3'b101 : icls == 2'd2 ? 3'b011 : icls == 2'd3 ? 3'b100 : 3'b000;
        ExtZero = icls[1];
        nxt = S_WBI;
      end
      S_WBI: RegWrite = 1'b1;
      S_BEQ, S_BNE: begin
        ALUSrcA = 1'b1;
        ALUOp = 3'b001;
        PCWriteCond = 1'b1;
        PCCondSrc = st == S_BEQ;
        PCSource = 2'b01;
      end
      S_J: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst = 2'b10;
        MemtoReg = 2'b10;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSource = 2'b11;
      end
      S_TRAP: begin
        illegal = 1'b1;
        nxt = S_TRAP;
      end
      default: nxt = S_IF;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench over four parameter variants of multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [4];
  logic [5:0] ops [4];
  logic [5:0] fns [4];
  logic mrs [4];
  logic [21:0] outs [4];
  logic [4:0] sts [4];
  int errors = 0;
  int checks = 0;
  typedef struct {logic [4:0] st; logic mr;} exp_t;
  exp_t sb [$];
  // u[0] defaults, u[1] no trap, u[2] no JAL/JR, u[3] no memory handshake
  for (genvar g = 0; g < 4; g++) begin : u
    logic pcw, pcwc, pccs, iord, mrd, mwr, irw, rw, asa, ez, ill;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
    multicycle_ctrl #(.MEM_HS(g != 3), .EN_JAL(g != 2), .TRAP_ILLEGAL(g != 1)) dut (
      .clk(clk), .rst(rst[g]), .OP(ops[g]), .funct(fns[g]), .mem_ready(mrs[g]),
      .PCWrite(pcw), .PCWriteCond(pcwc), .PCCondSrc(pccs), .IorD(iord), .MemRead(mrd),
      .MemWrite(mwr), .IRWrite(irw), .RegWrite(rw), .ALUSrcA(asa), .ExtZero(ez),
      .illegal(ill), .RegDst(rd), .MemtoReg(m2r), .ALUSrcB(asb), .PCSource(pcs),
      .ALUOp(aop), .state(sts[g]));
    assign outs[g] = {pcw, pcwc, pccs, iord, mrd, mwr, irw, rw, asa, ez, ill, rd, m2r, asb, pcs, aop};
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask
  // expected control word per state, written from the state/output table
  function automatic logic [21:0] model(logic [4:0] s, logic [5:0] op, logic mr, int n);
    logic pcw, pcwc, pccs, iord, mrd, mwr, irw, rw, asa, ez, ill;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, pccs, iord, mrd, mwr, irw, rw, asa, ez, ill} = '0;
    {rd, m2r, asb, pcs, aop} = '0;
    case (s)
      5'd0: begin mrd = 1; asb = 2'b01; pcw = mr || n == 3; irw = pcw; end
      5'd1: asb = 2'b11;
      5'd2: begin asa = 1; asb = 2'b10; end
      5'd3: begin mrd = 1; iord = 1; end
      5'd4: begin rw = 1; m2r = 2'b01; end
      5'd5: begin mwr = 1; iord = 1; end
      5'd6: begin asa = 1; aop = 3'b010; end
      5'd7: begin rw = 1; rd = 2'b01; end
      5'd8: begin asa = 1; aop = 3'b001; pcwc = 1; pccs = 1; pcs = 2'b01; end
      5'd9: begin pcw = 1; pcs = 2'b10; end
      5'd10: begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
      5'd11: begin
        asa = 1; asb = 2'b10;
        aop = op == 6'b001010 ? 3'b101 : op == 6'b001100 ? 3'b011 : op == 6'b001101 ? 3'b100 : 3'b000;
        ez = op == 6'b001100 || op == 6'b001101;
      end
      5'd12: rw = 1;
      5'd13: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      5'd14: begin pcw = 1; pcs = 2'b11; end
      5'd15: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, pccs, iord, mrd, mwr, irw, rw, asa, ez, ill, rd, m2r, asb, pcs, aop};
  endfunction
  task automatic push(logic [4:0] s, logic m = 1'b0, int k = 1);
    for (int i = 0; i < k; i++) sb.push_back('{s, m});
  endtask
  task automatic drain(int n, logic [5:0] o, logic [5:0] f);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ops[n] = o;
      fns[n] = f;
      mrs[n] = e.mr;
      #2;
      check($sformatf("u%0d op%06b state", n, o), 32'(sts[n]), 32'(e.st));
      check($sformatf("u%0d op%06b st%0d outs", n, o, e.st), 32'(outs[n]), 32'(model(e.st, o, e.mr, n)));
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(int n);
    rst[n] = 1'b1;
    mrs[n] = 1'b0;
    #2;
    check($sformatf("u%0d async reset state", n), 32'(sts[n]), 32'd31);
    check($sformatf("u%0d async reset outs", n), 32'(outs[n]), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("u%0d held reset state", n), 32'(sts[n]), 32'd31);
    check($sformatf("u%0d held reset outs", n), 32'(outs[n]), 32'd0);
    rst[n] = 1'b0;
  endtask
  task automatic short_instr(int n, logic [5:0] o, logic [5:0] f, logic [4:0] a, logic [4:0] b);
    do_reset(n);
    push(31);
    push(0, 1);
    push(1);
    push(a);
    if (b != 0) push(b);
    push(0);
    drain(n, o, f);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      ops[i] = '0;
      fns[i] = '0;
      mrs[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    do_reset(0);
    push(31); push(0, 1); push(1); push(2); push(3, 0, 2); push(3, 1); push(4); push(0);
    drain(0, 6'b100011, 6'd0);
    do_reset(0);
    push(31); push(0, 0, 3); push(0, 1); push(1); push(11); push(12); push(0);
    drain(0, 6'b001101, 6'd0);
    do_reset(0);
    push(31); push(0, 1); push(1); push(2); push(5, 0, 2); push(5, 1); push(0);
    drain(0, 6'b101011, 6'd0);
    short_instr(0, 6'b000010, 6'd0, 9, 0);
    short_instr(0, 6'b000011, 6'd0, 13, 0);
    short_instr(0, 6'b000000, 6'b001000, 14, 0);
    short_instr(0, 6'b000100, 6'd0, 8, 0);
    short_instr(0, 6'b000101, 6'd0, 10, 0);
    short_instr(0, 6'b000000, 6'b100000, 6, 7);
    short_instr(0, 6'b001000, 6'd0, 11, 12);
    short_instr(0, 6'b001010, 6'd0, 11, 12);
    short_instr(0, 6'b001100, 6'd0, 11, 12);
    do_reset(0);
    push(31); push(0, 1); push(1); push(15, 1, 10);
    drain(0, 6'b111111, 6'd0);
    do_reset(0);
    push(31); push(0);
    drain(0, 6'b111111, 6'd0);
    do_reset(0);
    push(31); push(0, 1); push(1); push(2); push(3, 0, 2);
    drain(0, 6'b100011, 6'd0);
    do_reset(0);
    push(31); push(0);
    drain(0, 6'b100011, 6'd0);
    short_instr(1, 6'b111111, 6'd0, 6, 7);
    do_reset(2);
    push(31); push(0, 1); push(1); push(15, 0, 3);
    drain(2, 6'b000011, 6'd0);
    short_instr(2, 6'b000000, 6'b001000, 6, 7);
    do_reset(3);
    push(31); push(0); push(1); push(2); push(3); push(4); push(0);
    drain(3, 6'b100011, 6'd0);
    do_reset(3);
    push(31); push(0); push(1); push(2); push(5); push(0);
    drain(3, 6'b101011, 6'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_HS, default 1: 1 means IF, MEM_RD and MEM_ST wait for mem_ready; 0 means each takes one cycle and mem_ready is ignored.
REQ-002 Parameter EN_JAL, default 1: 1 means JAL and JR are decoded; 0 means they are treated as undefined opcodes.
REQ-003 Parameter TRAP_ILLEGAL, default 1: 1 means an undefined opcode enters TRAP; 0 means it enters EX_R.
REQ-004 Reset rst, asynchronous, active-high; clock clk.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 OP  in  6  opcode from IR.
REQ-008 funct  in  6  function field from IR.
REQ-009 mem_ready  in  1  memory access complete this cycle.
REQ-010 PCWrite, PCWriteCond, PCCondSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtZero, illegal  out  1 each  datapath strobes/selects.
REQ-011 RegDst  out  2  register destination: 00 rt, 01 rd, 10 r31.
REQ-012 MemtoReg  out  2  write-back source: 00 ALUOut, 01 MDR, 10 PC.
REQ-013 ALUSrcB  out  2  ALU B source: 00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-014 PCSource  out  2  next-PC source: 00 ALU, 01 ALUOut, 10 jump target, 11 register A.
REQ-015 ALUOp  out  3  ALU operation: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
REQ-016 state  out  5  current state, registered.

Function
REQ-017 States SHALL be encoded as: IF 0, ID 1, EX_LS 2, MEM_RD 3, WB_LS 4, MEM_ST 5, EX_R 6, WB_R 7, BEQ 8, J 9, BNE 10, EX_I 11, WB_I 12, JAL 13, JR 14, TRAP 15, RESET 31.
REQ-018 All outputs except state SHALL be Moore outputs of state only; the sole exception is the mem_ready qualification defined in REQ-020.
REQ-019 Any output not listed for a state SHALL be 0.
REQ-020 IF outputs: MemRead=1, ALUSrcB=01; PCWrite=IRWrite=(mem_ready or MEM_HS=0).
REQ-021 IF transition: to ID when (mem_ready or MEM_HS=0), else hold in IF.
REQ-022 ID outputs: ALUSrcB=11.
REQ-023 ID decode: 000000 goes to JR if funct=001000 and EN_JAL, else to EX_R.
REQ-024 ID decode: 000010 to J; 000011 to JAL (if EN_JAL); 000100 to BEQ; 000101 to BNE.
REQ-025 ID decode: 001000, 001010, 001100 and 001101 go to EX_I.
REQ-026 ID decode: 100011 and 101011 go to EX_LS.
REQ-027 ID decode: any other opcode goes to TRAP if TRAP_ILLEGAL, else to EX_R.
REQ-028 EX_LS: ALUSrcA=1, ALUSrcB=10; go to MEM_RD for LW, to MEM_ST for SW.
REQ-029 MEM_RD: MemRead=1, IorD=1; go to WB_LS on ready (REQ-021 rule), else hold.
REQ-030 MEM_ST: MemWrite=1, IorD=1; go to IF on ready, else hold; MemWrite stays high throughout the wait.
REQ-031 WB_LS: RegWrite=1, MemtoReg=01, RegDst=00; go to IF.
REQ-032 EX_R: ALUSrcA=1, ALUOp=010; go to WB_R.
REQ-033 WB_R: RegWrite=1, RegDst=01; go to IF.
REQ-034 EX_I: ALUSrcA=1, ALUSrcB=10; go to WB_I.
REQ-035 EX_I ALUOp: 000 for ADDI, 101 for SLTI, 011 for ANDI, 100 for ORI; ExtZero=1 only for ANDI and ORI.
REQ-036 WB_I: RegWrite=1, RegDst=00, MemtoReg=00; go to IF.
REQ-037 BEQ: ALUSrcA=1, ALUOp=001, PCWriteCond=1, PCCondSrc=1, PCSource=01; go to IF.
REQ-038 BNE: identical to BEQ except PCCondSrc=0; go to IF.
REQ-039 J: PCWrite=1, PCSource=10; go to IF.
REQ-040 JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; go to IF. The PC already holds PC+4 at this point.
REQ-041 JR: PCWrite=1, PCSource=11; go to IF.
REQ-042 TRAP: illegal=1, all other outputs 0; hold until rst.
REQ-043 RESET (31) and any unused encoding SHALL output all zeros and go to IF on the next edge.

Reset
REQ-044 rst=1 SHALL force state=31 immediately (asynchronously) from any state, including mid-wait or TRAP, abandoning the current instruction.
REQ-045 While rst=1 all outputs SHALL be 0, and they SHALL remain 0 for the first cycle after release.
REQ-046 The power-up (initial) state SHALL be 31.

Verification
REQ-047 Reset released; LW (100011); MEM_HS=1; mem_ready low 2 cycles in MEM_RD -> states 31,0,1,2,3,3,3,4,0; RegWrite=1 and MemtoReg=01 only in state 4.
REQ-048 mem_ready low 3 cycles in IF -> PCWrite=IRWrite=0 for 3 cycles, then 1 for exactly one cycle, then state=1.
REQ-049 ORI (001101) -> states 1,11,12,0; in state 11 ALUOp=100 and ExtZero=1; in state 12 RegWrite=1 and RegDst=00.
REQ-050 JAL (000011), EN_JAL=1 -> state 13 with PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10. JR (OP 0, funct 001000) -> state 14 with PCSource=11.
REQ-051 Opcode 111111, TRAP_ILLEGAL=1 -> state 15, illegal=1, held 10 cycles; then rst pulse -> state 31, then 0.
REQ-052 Same opcode with TRAP_ILLEGAL=0 -> states 6,7,0; with EN_JAL=0, JAL opcode goes to TRAP.
